// File: rtl/ex_div_stallreq_unit_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// The master side is EX/controller and the slave side is the divider.
interface ex_div_stallreq_unit_if #(
  parameter int WIDTH   = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_signed;
  logic               cancel;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   result_lo;
  logic [WIDTH-1:0]   result_hi;
  logic               ready;
  logic               busy;
  logic               stallreq_for_ex;

  modport master (
    output stall, div_start, div_signed, cancel, op_a, op_b,
    input  result_lo, result_hi, ready, busy, stallreq_for_ex
  );

  modport slave (
    input  stall, div_start, div_signed, cancel, op_a, op_b,
    output result_lo, result_hi, ready, busy, stallreq_for_ex
  );
endinterface

// File: rtl/ex_div_stallreq_unit.sv
// EX-stage restoring divider (MIPS DIV/DIVU) that raises the EX stall request.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module ex_div_stallreq_unit #(
  parameter int WIDTH   = 32,
  parameter int STALL_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_div_stallreq_unit_if.slave dif
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem, quot, dvsr, a_raw;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             rdy;

  logic             a_neg, b_neg, early, fit;
  logic [WIDTH-1:0] abs_a, abs_b, rem_n, quot_n, q_fin, r_fin;
  logic [WIDTH:0]   pr, diff;

  always_comb begin
    a_neg = dif.div_signed & dif.op_a[WIDTH-1];
    b_neg = dif.div_signed & dif.op_b[WIDTH-1];
    abs_a = a_neg ? -dif.op_a : dif.op_a;
    abs_b = b_neg ? -dif.op_b : dif.op_b;
    early = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    early = (abs_b != '0) && (abs_a < abs_b);
`endif
    // One restoring step: shift {rem,quot} left, trial-subtract on WIDTH+1 bits.
    pr     = {rem, quot[WIDTH-1]};
    fit    = pr >= {1'b0, dvsr};
    diff   = pr - {1'b0, dvsr};
    rem_n  = fit ? diff[WIDTH-1:0] : pr[WIDTH-1:0];
    quot_n = {quot[WIDTH-2:0], fit};
    q_fin  = neg_q ? -quot_n : quot_n;
    r_fin  = neg_r ? -rem_n  : rem_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      quot   <= '0;
      dvsr   <= '0;
      a_raw  <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
      rdy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dif.div_start && !dif.cancel) begin
          a_raw <= dif.op_a;
          dvsr  <= abs_b;
          rem   <= '0;
          cnt   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          // ZERO doubles as the one-cycle path for divide-by-zero and early-out.
          if (abs_b == '0) begin
            quot  <= '1;
            state <= ZERO;
          end else if (early) begin
            quot  <= '0;
            state <= ZERO;
          end else begin
            quot  <= abs_a;
            state <= ON;
          end
        end
        ZERO: if (dif.cancel) begin
          state <= IDLE;
        end else begin
          res_lo <= quot;
          res_hi <= a_raw;
          rdy    <= 1'b1;
          state  <= END;
        end
        ON: if (dif.cancel) begin
          state <= IDLE;
        end else begin
          rem  <= rem_n;
          quot <= quot_n;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            res_lo <= q_fin;
            res_hi <= r_fin;
            rdy    <= 1'b1;
            state  <= END;
          end
        end
        END: if (dif.cancel || !dif.stall[3]) begin
          rdy   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_stall;
  assign unused_stall = ^{dif.stall[STALL_W-1:4], dif.stall[2:0]};

  assign dif.result_lo       = res_lo;
  assign dif.result_hi       = res_hi;
  assign dif.ready           = rdy;
  assign dif.busy            = (state != IDLE);
  assign dif.stallreq_for_ex = dif.div_start & (state != END) & ~dif.cancel;
endmodule

// File: tb/tb_ex_div_stallreq_unit.sv
// Directed bench for ex_div_stallreq_unit: latency/result model checked every cycle
// plus literal expectations for each directed divide.
module tb_ex_div_stallreq_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  ex_div_stallreq_unit_if #(.WIDTH(32), .STALL_W(6)) dif();
  ex_div_stallreq_unit #(.WIDTH(32), .STALL_W(6)) dut (.clk(clk), .rst(rst), .dif(dif));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference results from plain integer division: {hi, lo}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 0 || (EARLY && ma < mb)) return 2;
    return 33;
  endfunction

  // Transaction-level model: countdown to ready, then hold while stall[3].
  bit          m_busy = 0, m_ready = 0;
  int          m_wait = 0;
  logic [31:0] m_lo = 0, m_hi = 0, p_lo = 0, p_hi = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_ready <= 0; m_lo <= 0; m_hi <= 0;
    end else if (m_ready) begin
      if (dif.cancel || !dif.stall[3]) begin m_ready <= 0; m_busy <= 0; end
    end else if (m_busy) begin
      if (dif.cancel) m_busy <= 0;
      else if (m_wait == 1) begin m_ready <= 1; m_lo <= p_lo; m_hi <= p_hi; end
      else m_wait <= m_wait - 1;
    end else if (dif.div_start && !dif.cancel) begin
      m_busy <= 1;
      m_wait <= ref_lat(dif.op_a, dif.op_b, dif.div_signed) - 1;
      {p_hi, p_lo} <= ref_div(dif.op_a, dif.op_b, dif.div_signed);
    end
  end

  always @(negedge clk) if (cmp_en) begin
    chk("m_ready", {31'd0, dif.ready}, {31'd0, m_ready});
    chk("m_busy",  {31'd0, dif.busy},  {31'd0, m_busy});
    chk("m_stallreq", {31'd0, dif.stallreq_for_ex},
        {31'd0, dif.div_start & ~dif.cancel & ~m_ready});
    chk("m_lo", dif.result_lo, m_lo);
    chk("m_hi", dif.result_hi, m_hi);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start a divide in cycle 0 and wait for ready; leaves start high in the ready cycle.
  task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int lat, input logic [31:0] lo, input logic [31:0] hi);
    int cyc;
    dif.op_a = a; dif.op_b = b; dif.div_signed = s; dif.div_start = 1'b1;
    cyc = 0;
    @(negedge clk);
    chk({nm, "_stallreq_c0"}, {31'd0, dif.stallreq_for_ex}, 32'd1);
    while (!dif.ready && cyc < 60) begin
      tick(); cyc++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_lo"}, dif.result_lo, lo);
    chk({nm, "_hi"}, dif.result_hi, hi);
    chk({nm, "_stallreq_end"}, {31'd0, dif.stallreq_for_ex}, 32'd0);
  endtask

  task automatic drop_start();
    tick();
    dif.div_start = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, dif.busy}, 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] lo_s, hi_s;
    rst = 1'b1;
    dif.stall = '0; dif.div_start = 0; dif.div_signed = 0; dif.cancel = 0;
    dif.op_a = '0; dif.op_b = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ready", {31'd0, dif.ready}, 32'd0);
    chk("rst_busy",  {31'd0, dif.busy},  32'd0);
    chk("rst_lo", dif.result_lo, 32'd0);
    chk("rst_hi", dif.result_hi, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_div("divu_100_7", 32'd100, 32'd7, 0, 33, 32'd14, 32'd2);
    drop_start();
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    drop_start();
    do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1, 33, 32'hFFFF_FFFD, 32'd1);
    drop_start();
    do_div("divu_by0", 32'h1234, 32'd0, 0, 2, 32'hFFFF_FFFF, 32'h1234);
    drop_start();
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 33, 32'h8000_0000, 32'd0);
    drop_start();
    do_div("divu_max", 32'hFFFF_FFFF, 32'd1, 0, 33, 32'hFFFF_FFFF, 32'd0);
    drop_start();

    // Results held while stall[3] freezes EX in END.
    dif.stall = 6'b001000;
    do_div("hold", 32'd1000, 32'd33, 0, 33, 32'd30, 32'd10);
    lo_s = dif.result_lo; hi_s = dif.result_hi;
    for (int i = 0; i < 2; i++) begin
      tick(); @(negedge clk);
      chk("hold_ready", {31'd0, dif.ready}, 32'd1);
      chk("hold_lo", dif.result_lo, lo_s);
      chk("hold_hi", dif.result_hi, hi_s);
    end
    tick(); dif.stall = '0;
    @(negedge clk);
    chk("hold_last_ready", {31'd0, dif.ready}, 32'd1);
    drop_start();

    // Cancel in cycle 10 of the divide.
    dif.op_a = 32'd500; dif.op_b = 32'd3; dif.div_signed = 0; dif.div_start = 1;
    for (int i = 0; i < 10; i++) tick();
    dif.cancel = 1'b1;
    @(negedge clk);
    chk("cancel_stallreq", {31'd0, dif.stallreq_for_ex}, 32'd0);
    tick(); dif.cancel = 1'b0; dif.div_start = 1'b0;
    @(negedge clk);
    chk("cancel_busy", {31'd0, dif.busy}, 32'd0);
    for (int i = 0; i < 30; i++) tick();

    // Reset in cycle 20 of the divide.
    dif.op_a = 32'd1000; dif.op_b = 32'd3; dif.div_start = 1;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick(); rst = 1'b0; dif.div_start = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, dif.busy}, 32'd0);
    chk("rst_mid_lo", dif.result_lo, 32'd0);
    chk("rst_mid_hi", dif.result_hi, 32'd0);
    tick();
    do_div("divu_9_3", 32'd9, 32'd3, 0, 33, 32'd3, 32'd0);
    drop_start();
    do_div("divu_3_9", 32'd3, 32'd9, 0, EARLY ? 2 : 33, 32'd0, 32'd3);
    drop_start();
    do_div("div_m3_9", 32'hFFFF_FFFD, 32'd9, 1, EARLY ? 2 : 33, 32'd0, 32'hFFFF_FFFD);
    drop_start();

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
